// File: rtl/multi_mod_counter_if.sv
// Bundle of per-channel controls, the terminal-value write handshake and the
// counter outputs for multi_mod_counter. The master drives, the slave (counter) responds.
interface multi_mod_counter_if #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 3
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       dir;
    logic [CHANNELS-1:0]       cascade;
    // A write to channel cfg_ch is taken on a rising edge where cfg_valid and
    // cfg_ready are both 1; cfg_ready is combinational from cfg_ch and is never
    // asserted for a channel index outside 0..CHANNELS-1.
    logic                      cfg_valid;
    logic [CW-1:0]             cfg_ch;
    logic [WIDTH-1:0]          cfg_term;
    logic                      cfg_ready;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       tc;
    logic [CHANNELS-1:0]       div_out;

    modport master (
        output en, dir, cascade, cfg_valid, cfg_ch, cfg_term,
        input  cfg_ready, count, tc, div_out
    );

    modport slave (
        input  en, dir, cascade, cfg_valid, cfg_ch, cfg_term,
        output cfg_ready, count, tc, div_out
    );
endinterface

// File: rtl/multi_mod_counter.sv
// Multi-channel modulo up/down counter with per-channel terminal value, wrap pulse and
// divided clock. Optional same-cycle cascade chaining under MULTI_MOD_COUNTER_CASCADE_EN.
module multi_mod_counter #(
    parameter int WIDTH        = 3,
    parameter int CHANNELS     = 3,
    parameter int DEFAULT_TERM = 5
) (
    input logic                  clk,
    input logic                  rst,
    multi_mod_counter_if.slave   bus
);
    logic [WIDTH-1:0]    count_q  [CHANNELS];
    logic [WIDTH-1:0]    term_q   [CHANNELS];
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] tc_q;
    logic [CHANNELS-1:0] div_q;
    logic [CHANNELS-1:0] adv;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] cfg_hit;
    logic                cfg_ready;

    // Out-of-range channel indices match no channel, so ready stays 0.
    always_comb begin : ready_decode
        cfg_ready = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(bus.cfg_ch) == i) cfg_ready = !pending_q[i];
        end
    end

    always_comb begin : advance_chain
`ifdef MULTI_MOD_COUNTER_CASCADE_EN
        logic carry;
        carry = 1'b0;
`endif
        adv     = '0;
        wrap    = '0;
        cfg_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef MULTI_MOD_COUNTER_CASCADE_EN
            // carry holds wrap of the previous channel, giving a same-cycle ripple.
            adv[i] = (i > 0 && bus.cascade[i]) ? (bus.en[i] & carry) : bus.en[i];
`else
            adv[i] = bus.en[i];
`endif
            wrap[i] = adv[i] & (bus.dir[i] ? (count_q[i] == '0)
                                           : (count_q[i] == term_q[i]));
`ifdef MULTI_MOD_COUNTER_CASCADE_EN
            carry = wrap[i];
`endif
            cfg_hit[i] = bus.cfg_valid & cfg_ready & (int'(bus.cfg_ch) == i);
        end
    end

`ifndef MULTI_MOD_COUNTER_CASCADE_EN
    logic unused_cascade;
    assign unused_cascade = ^bus.cascade;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]   <= '0;
                term_q[i]    <= WIDTH'(DEFAULT_TERM);
                shadow_q[i]  <= '0;
                pending_q[i] <= 1'b0;
                tc_q[i]      <= 1'b0;
                div_q[i]     <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                tc_q[i]  <= wrap[i];
                div_q[i] <= div_q[i] ^ wrap[i];
                if (pending_q[i] && !bus.en[i]) begin
                    // Channel stopped with a write outstanding: apply it now.
                    term_q[i]    <= shadow_q[i];
                    count_q[i]   <= '0;
                    pending_q[i] <= 1'b0;
                end else if (cfg_hit[i] && !bus.en[i]) begin
                    term_q[i]  <= bus.cfg_term;
                    count_q[i] <= '0;
                end else begin
                    if (cfg_hit[i]) begin
                        shadow_q[i]  <= bus.cfg_term;
                        pending_q[i] <= 1'b1;
                    end
                    if (wrap[i]) begin
                        if (pending_q[i]) begin
                            term_q[i]    <= shadow_q[i];
                            pending_q[i] <= 1'b0;
                            count_q[i]   <= bus.dir[i] ? shadow_q[i] : '0;
                        end else begin
                            count_q[i]   <= bus.dir[i] ? term_q[i] : '0;
                        end
                    end else if (adv[i]) begin
                        count_q[i] <= bus.dir[i] ? (count_q[i] - 1'b1)
                                                 : (count_q[i] + 1'b1);
                    end
                end
            end
        end
    end

    always_comb begin : pack_outputs
        bus.count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.count[i*WIDTH +: WIDTH] = count_q[i];
        end
    end

    assign bus.tc        = tc_q;
    assign bus.div_out   = div_q;
    assign bus.cfg_ready = cfg_ready;
endmodule
